step_dtack_ctrl: RTL and testbench
==================================

STEP_DTACK_CTRL -- requirements
Module: step_dtack_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, range 0..15: clocks inserted before DTACK in run mode.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000, range 1..65535: clocks STEP_IN must stay stable before its level is accepted.
REQ-003 SHALL have port CPUCLK_IN, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port RESET_IN, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port RUN_IN, input, 1: CPU released from reset/halt; low forces idle.
REQ-006 SHALL have port STEPEN_IN, input, 1: single-step mode select, asynchronous switch.
REQ-007 SHALL have port STEP_IN, input, 1: step push-button, asynchronous, bouncing.
REQ-008 SHALL have port AS_IN, input, 1: address strobe, asserted high, asynchronous.
REQ-009 SHALL have ports UDS_IN and LDS_IN, input, 1 each: data strobes, asserted high, asynchronous.
REQ-010 SHALL have port DTACK, output, 1: data transfer acknowledge, asserted high, registered.
REQ-011 SHALL have port STEP_PENDING, output, 1: one step token is held.
REQ-012 SHALL have port CYCLE_COUNT, output, 16: completed acknowledged bus cycles.

Function
REQ-013 SHALL synchronise STEPEN_IN, STEP_IN, AS_IN, UDS_IN, LDS_IN through two flip-flops each; logic uses only the second-stage (_s) values.
REQ-014 SHALL debounce STEP_s: counter reloads whenever STEP_s differs from debounced level; debounced level takes STEP_s after DEBOUNCE_CYCLES consecutive stable clocks.
REQ-015 SHALL set the step token on a rising edge of the debounced level; token holds at most one step; presses while set are discarded.
REQ-016 SHALL implement FSM states IDLE, WAIT, STEP_WAIT, ACK.
REQ-017 IDLE: when RUN_IN & AS_s & (UDS_s | LDS_s): go STEP_WAIT if STEPEN_s=1; else go ACK if WAIT_STATES=0, else go WAIT loading wait counter with WAIT_STATES.
REQ-018 WAIT: counter==1 -> ACK; else decrement.
REQ-019 STEP_WAIT: token set -> clear token, go ACK; token arriving and consumed in the same clock SHALL be consumed exactly once.
REQ-020 ACK: DTACK=1; stay while AS_s=1; AS_s=0 -> IDLE and CYCLE_COUNT+1.
REQ-021 DTACK SHALL be 1 only in ACK (Moore, registered).
REQ-022 Latency: strobes valid before edge N -> FSM leaves IDLE at edge N+2 -> DTACK high after edge N+2+WAIT_STATES in run mode.
REQ-023 AS_IN released before edge M while in ACK -> DTACK low after edge M+2.
REQ-024 AS_s=0 in WAIT or STEP_WAIT (aborted cycle) -> IDLE, no DTACK, no count increment, token unchanged.
REQ-025 RUN_IN=0 in any state -> IDLE next clock, DTACK 0, token cleared, count unchanged.
REQ-026 STEPEN_s sampled only on IDLE exit; changes mid-cycle SHALL NOT affect current cycle.
REQ-027 Token SHALL persist in IDLE and across cycles until consumed or cleared.
REQ-028 CYCLE_COUNT SHALL wrap 16'hFFFF -> 0.
REQ-029 STEP_PENDING SHALL equal the token register.

Reset
REQ-030 RESET_IN=1 at a rising edge SHALL give: state IDLE, DTACK 0, token 0, STEP_PENDING 0, CYCLE_COUNT 0, wait counter 0, debounced level 0, debounce counter reloaded, synchronisers 0.
REQ-031 Reset mid-cycle (any state) SHALL abort without DTACK pulse or count increment; reset overrides all other inputs.

Verification
REQ-032 Run mode, WAIT_STATES=2: RUN_IN=1, AS/LDS asserted before edge 10 -> DTACK rises after edge 14; AS released before edge 20 -> DTACK falls after edge 22, CYCLE_COUNT=1.
REQ-033 Step mode, DEBOUNCE_CYCLES=4: bus cycle starts, no press -> DTACK stays 0 for 100 clocks; clean STEP_IN press -> DTACK asserts, STEP_PENDING 1 then 0.
REQ-034 Bounce: STEP_IN toggled every 2 clocks for 20 clocks then held high -> exactly one token; second press while pending -> still one token, one DTACK per cycle.
REQ-035 Abort: AS released in WAIT -> no DTACK, CYCLE_COUNT unchanged; pending token survives to next step cycle.
REQ-036 Wrap/RUN: preload via 65535 cycles -> next completion gives CYCLE_COUNT=0; RUN_IN=0 during ACK -> DTACK 0 after one edge, IDLE.
REQ-037 Reset during ACK with token pending -> DTACK 0, STEP_PENDING 0, CYCLE_COUNT 0 after the reset edge.

Source files
------------

// File: rtl/step_dtack_ctrl.sv
// DTACK generator for a 68k-style bus: run mode inserts WAIT_STATES clocks,
// single-step mode holds each bus cycle until a debounced STEP press supplies a token.
module step_dtack_ctrl #(
    parameter int unsigned WAIT_STATES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic        CPUCLK_IN,
    input  logic        RESET_IN,
    input  logic        RUN_IN,
    input  logic        STEPEN_IN,
    input  logic        STEP_IN,
    input  logic        AS_IN,
    input  logic        UDS_IN,
    input  logic        LDS_IN,
    output logic        DTACK,
    output logic        STEP_PENDING,
    output logic [15:0] CYCLE_COUNT,
    output logic [1:0]  DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_ACK       = 2'd3
    } state_t;

    localparam logic [15:0] DEB_RELOAD = 16'(DEBOUNCE_CYCLES);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

    // Bus protocol: a cycle starts when AS and either data strobe are seen with RUN
    // high; DTACK is held until AS is released, which completes the cycle.

    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;
    logic        stepen_s;
    logic        step_s;
    logic        as_s;
    logic        uds_s;
    logic        lds_s;

    logic        deb_level_q;
    logic [15:0] deb_cnt_q;
    logic        step_rise;

    state_t      state_q;
    state_t      state_next;
    logic [3:0]  wait_cnt_q;
    logic        token_q;
    logic [15:0] cycle_count_q;
    logic        dtack_q;

    logic        wait_load;
    logic        wait_dec;
    logic        token_consume;
    logic        token_clear;
    logic        cycle_done;

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {STEPEN_IN, STEP_IN, AS_IN, UDS_IN, LDS_IN};
            sync2_q <= sync1_q;
        end
    end

    assign {stepen_s, step_s, as_s, uds_s, lds_s} = sync2_q;

    // The level is accepted on the last of DEBOUNCE_CYCLES consecutive differing clocks.
    assign step_rise = step_s && !deb_level_q && (deb_cnt_q <= 16'd1);

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            deb_level_q <= 1'b0;
            deb_cnt_q   <= DEB_RELOAD;
        end else if (step_s == deb_level_q) begin
            deb_cnt_q   <= DEB_RELOAD;
        end else if (deb_cnt_q <= 16'd1) begin
            deb_level_q <= step_s;
            deb_cnt_q   <= DEB_RELOAD;
        end else begin
            deb_cnt_q   <= deb_cnt_q - 16'd1;
        end
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (!RUN_IN) begin
            state_next = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (as_s && (uds_s || lds_s)) begin
                        if (stepen_s)
                            state_next = ST_STEP_WAIT;
                        else if (WAIT_LOAD == 4'd0)
                            state_next = ST_ACK;
                        else
                            state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!as_s)
                        state_next = ST_IDLE;
                    else if (wait_cnt_q <= 4'd1)
                        state_next = ST_ACK;
                end
                ST_STEP_WAIT: begin
                    if (!as_s)
                        state_next = ST_IDLE;
                    else if (token_q)
                        state_next = ST_ACK;
                end
                ST_ACK: begin
                    if (!as_s)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wait_load     = (state_q == ST_IDLE) && (state_next == ST_WAIT);
        wait_dec      = (state_q == ST_WAIT) && (state_next == ST_WAIT);
        token_consume = (state_q == ST_STEP_WAIT) && (state_next == ST_ACK);
        token_clear   = !RUN_IN || token_consume;
        cycle_done    = (state_q == ST_ACK) && RUN_IN && !as_s;
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            wait_cnt_q <= '0;
        end else if (wait_load) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if (wait_dec) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    // Clearing wins over a new press, so a press landing on the consuming clock is dropped.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            token_q <= 1'b0;
        end else if (token_clear) begin
            token_q <= 1'b0;
        end else if (step_rise) begin
            token_q <= 1'b1;
        end
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            cycle_count_q <= '0;
            dtack_q       <= 1'b0;
        end else begin
            if (cycle_done)
                cycle_count_q <= cycle_count_q + 16'd1;
            dtack_q <= (state_next == ST_ACK);
        end
    end

    assign DTACK        = dtack_q;
    assign STEP_PENDING = token_q;
    assign CYCLE_COUNT  = cycle_count_q;
    assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_step_dtack_ctrl.sv
// Bench for step_dtack_ctrl: table of run-mode vectors, then hand sequences
// for step mode, bounce, aborts, reset in ACK and count wrap.
module tb_step_dtack_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        stepen;
  logic        step;
  logic        as_;
  logic        uds;
  logic        lds;
  logic        dtack;
  logic        pend;
  logic [15:0] count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_count;
  logic        seen;

  step_dtack_ctrl #(
    .WAIT_STATES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CPUCLK_IN    (clk),
    .RESET_IN     (rst),
    .RUN_IN       (run),
    .STEPEN_IN    (stepen),
    .STEP_IN      (step),
    .AS_IN        (as_),
    .UDS_IN       (uds),
    .LDS_IN       (lds),
    .DTACK        (dtack),
    .STEP_PENDING (pend),
    .CYCLE_COUNT  (count),
    .DBG_STATE    (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        run;
    logic        as_;
    logic        uds;
    logic        lds;
    int          clks;
    logic        exp_dtack;
    logic        exp_pend;
    logic [15:0] exp_count;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic r, input logic rn, input logic a, input logic u,
                              input logic l, input int c, input logic ed, input logic ep,
                              input logic [15:0] ec, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.run = rn; v.as_ = a; v.uds = u; v.lds = l; v.clks = c;
    v.exp_dtack = ed; v.exp_pend = ep; v.exp_count = ec; v.exp_state = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_dtack(input logic lvl, input string name);
    int n;
    n = 0;
    while (dtack !== lvl && n < 40) begin
      clocks(1);
      n++;
    end
    chk(name, {31'd0, dtack}, {31'd0, lvl});
  endtask

  task automatic run_cycle(input string name);
    as_ = 1'b1; lds = 1'b1;
    wait_dtack(1'b1, {name, "_ack"});
    as_ = 1'b0; lds = 1'b0;
    wait_dtack(1'b0, {name, "_release"});
  endtask

  task automatic press_step();
    step = 1'b1; clocks(8);
    step = 1'b0; clocks(8);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stepen = 1'b0; step = 1'b0;
    as_ = 1'b0; uds = 1'b0; lds = 1'b0;

    // rst run as uds lds clks | dtack pend count state
    vecs[0]  = mk(1, 0, 0, 0, 0, 2, 0, 0, 16'd0, 2'd0);
    vecs[1]  = mk(0, 1, 1, 0, 1, 3, 0, 0, 16'd0, 2'd1);
    vecs[2]  = mk(0, 1, 1, 0, 1, 1, 0, 0, 16'd0, 2'd1);
    vecs[3]  = mk(0, 1, 1, 0, 1, 1, 1, 0, 16'd0, 2'd3);
    vecs[4]  = mk(0, 1, 1, 0, 1, 4, 1, 0, 16'd0, 2'd3);
    vecs[5]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 16'd0, 2'd3);
    vecs[6]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 16'd0, 2'd3);
    vecs[7]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 16'd1, 2'd0);
    vecs[8]  = mk(0, 1, 1, 0, 0, 6, 0, 0, 16'd1, 2'd0);
    vecs[9]  = mk(0, 1, 1, 1, 0, 3, 0, 0, 16'd1, 2'd1);
    vecs[10] = mk(0, 1, 1, 1, 0, 2, 1, 0, 16'd1, 2'd3);
    vecs[11] = mk(0, 1, 0, 0, 0, 3, 0, 0, 16'd2, 2'd0);
    vecs[12] = mk(0, 0, 1, 0, 1, 6, 0, 0, 16'd2, 2'd0);
    vecs[13] = mk(0, 1, 1, 0, 1, 1, 0, 0, 16'd2, 2'd1);
    vecs[14] = mk(0, 0, 1, 0, 1, 1, 0, 0, 16'd2, 2'd0);
    vecs[15] = mk(0, 0, 0, 0, 0, 3, 0, 0, 16'd2, 2'd0);
    vecs[16] = mk(0, 1, 1, 0, 1, 2, 0, 0, 16'd2, 2'd0);
    vecs[17] = mk(0, 1, 0, 0, 0, 1, 0, 0, 16'd2, 2'd1);
    vecs[18] = mk(0, 1, 0, 0, 0, 2, 0, 0, 16'd2, 2'd0);
    vecs[19] = mk(0, 1, 1, 0, 1, 5, 1, 0, 16'd2, 2'd3);
    vecs[20] = mk(0, 0, 1, 0, 1, 1, 0, 0, 16'd2, 2'd0);
    vecs[21] = mk(0, 0, 0, 0, 0, 3, 0, 0, 16'd2, 2'd0);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; run = vecs[i].run; as_ = vecs[i].as_;
      uds = vecs[i].uds; lds = vecs[i].lds;
      clocks(vecs[i].clks);
      chk($sformatf("v%0d_dtack", i), {31'd0, dtack}, {31'd0, vecs[i].exp_dtack});
      chk($sformatf("v%0d_pend", i), {31'd0, pend}, {31'd0, vecs[i].exp_pend});
      chk($sformatf("v%0d_count", i), {16'd0, count}, {16'd0, vecs[i].exp_count});
      chk($sformatf("v%0d_state", i), {30'd0, dbg_state}, {30'd0, vecs[i].exp_state});
    end
    exp_count = 16'd2;

    // Step mode with no press: the cycle must hang, even if STEPEN flips mid-cycle.
    run = 1'b1; stepen = 1'b1; clocks(3);
    as_ = 1'b1; lds = 1'b1; clocks(3);
    chk("step_enter_state", {30'd0, dbg_state}, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) stepen = 1'b0;
      clocks(1);
      if (dtack) seen = 1'b1;
    end
    stepen = 1'b1;
    chk("step_nopress_dtack", {31'd0, seen}, 32'd0);
    chk("step_nopress_state", {30'd0, dbg_state}, 32'd2);

    // Clean press: token appears on the 6th edge, is consumed on the 7th.
    step = 1'b1; clocks(5);
    chk("press_pend_early", {31'd0, pend}, 32'd0);
    clocks(1);
    chk("press_pend_set", {31'd0, pend}, 32'd1);
    chk("press_dtack_wait", {31'd0, dtack}, 32'd0);
    clocks(1);
    chk("press_pend_used", {31'd0, pend}, 32'd0);
    chk("press_dtack", {31'd0, dtack}, 32'd1);
    as_ = 1'b0; lds = 1'b0; step = 1'b0; clocks(3);
    exp_count++;
    chk("press_dtack_off", {31'd0, dtack}, 32'd0);
    chk("press_count", {16'd0, count}, {16'd0, exp_count});
    clocks(8);

    // Bouncing button: only the final steady level produces a token.
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step = (k % 2 == 0);
      clocks(2);
      if (pend) seen = 1'b1;
    end
    chk("bounce_no_early_token", {31'd0, seen}, 32'd0);
    step = 1'b1; clocks(10);
    chk("bounce_token", {31'd0, pend}, 32'd1);
    step = 1'b0; clocks(8);
    press_step();
    chk("second_press_pend", {31'd0, pend}, 32'd1);
    run_cycle("bounce_cycle");
    exp_count++;
    clocks(2);
    chk("bounce_pend_used", {31'd0, pend}, 32'd0);
    chk("bounce_count", {16'd0, count}, {16'd0, exp_count});
    as_ = 1'b1; lds = 1'b1; clocks(30);
    chk("no_second_token_dtack", {31'd0, dtack}, 32'd0);
    chk("no_second_token_state", {30'd0, dbg_state}, 32'd2);
    as_ = 1'b0; lds = 1'b0; clocks(3);
    chk("step_abort_state", {30'd0, dbg_state}, 32'd0);
    chk("step_abort_count", {16'd0, count}, {16'd0, exp_count});

    // Abort in WAIT keeps the token; the next step cycle uses it.
    press_step();
    chk("abort_token_set", {31'd0, pend}, 32'd1);
    stepen = 1'b0; clocks(3);
    as_ = 1'b1; lds = 1'b1; clocks(2);
    as_ = 1'b0; lds = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clocks(1);
      if (dtack) seen = 1'b1;
    end
    chk("wait_abort_dtack", {31'd0, seen}, 32'd0);
    chk("wait_abort_count", {16'd0, count}, {16'd0, exp_count});
    chk("wait_abort_pend", {31'd0, pend}, 32'd1);
    chk("wait_abort_state", {30'd0, dbg_state}, 32'd0);
    stepen = 1'b1; clocks(3);
    run_cycle("token_survive");
    exp_count++;
    clocks(2);
    chk("token_survive_pend", {31'd0, pend}, 32'd0);
    chk("token_survive_count", {16'd0, count}, {16'd0, exp_count});

    // Reset while acknowledging with a token held.
    press_step();
    stepen = 1'b0; clocks(3);
    as_ = 1'b1; lds = 1'b1;
    wait_dtack(1'b1, "rst_ack_reach");
    chk("rst_ack_pend_before", {31'd0, pend}, 32'd1);
    rst = 1'b1; clocks(1);
    chk("rst_ack_dtack", {31'd0, dtack}, 32'd0);
    chk("rst_ack_pend", {31'd0, pend}, 32'd0);
    chk("rst_ack_count", {16'd0, count}, 32'd0);
    chk("rst_ack_state", {30'd0, dbg_state}, 32'd0);
    as_ = 1'b0; lds = 1'b0; clocks(3);
    rst = 1'b0; clocks(2);
    exp_count = 16'd0;

    // Counter wrap from a preloaded all-ones value.
    force dut.cycle_count_q = 16'hFFFF;
    clocks(1);
    release dut.cycle_count_q;
    clocks(1);
    chk("wrap_preload", {16'd0, count}, 32'h0000FFFF);
    run_cycle("wrap_cycle");
    clocks(2);
    chk("wrap_count", {16'd0, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
